// File: rtl/serial_frame_tx.sv
// Byte-to-serial transmitter: small FIFO feeding a start/8N/stop framer.
// Frames leave LSB-first on ser_out; back-to-back frames have no idle gap.
module serial_frame_tx #(
  parameter int CLKS_PER_BIT = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_accept,
  input  logic       hold,
  output logic       ser_out,
  output logic       busy
);

  // state | meaning
  // IDLE  | line at 1, waiting for a buffered byte with hold low
  // START | start bit (0) for CLKS_PER_BIT cycles
  // DATA  | data bits, shreg[0] on the line, LSB first
  // STOP  | stop bit (1); may chain straight into the next START
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] FULL   = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);

  state_t        state;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [7:0]    shreg;
  logic [TW-1:0] timer;
  logic [2:0]    bit_idx;

  logic push;
  logic pop;
  logic bit_end;
  logic can_start;

  assign data_accept = (count != FULL);
  assign push        = data_valid && data_accept;
  assign bit_end     = (timer == T_LAST);
  assign can_start   = (count != '0) && !hold;
  assign busy        = (state != IDLE) || (count != '0);

  // hold only matters at the two frame-start decision points
  always_comb begin
    pop = 1'b0;
    case (state)
      IDLE:    pop = can_start;
      STOP:    pop = bit_end && can_start;
      default: pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // ser_out is loaded with the level of the state being entered
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      ser_out <= 1'b1;
      shreg   <= '0;
      timer   <= '0;
      bit_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          ser_out <= 1'b1;
          timer   <= '0;
          if (pop) begin
            shreg   <= mem[rd_ptr];
            ser_out <= 1'b0;
            state   <= START;
          end
        end
        START: begin
          if (bit_end) begin
            timer   <= '0;
            bit_idx <= '0;
            ser_out <= shreg[0];
            state   <= DATA;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            timer <= '0;
            shreg <= {1'b0, shreg[7:1]};
            if (bit_idx == 3'd7) begin
              ser_out <= 1'b1;
              state   <= STOP;
            end else begin
              ser_out <= shreg[1];
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            timer <= '0;
            if (pop) begin
              shreg   <= mem[rd_ptr];
              ser_out <= 1'b0;
              state   <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: two instances (1 and 4 clocks per bit) checked by a
// line decoder and a write-order scoreboard, plus directed waveform checks.
module tb_serial_frame_tx;

  localparam int CPB0  = 1;
  localparam int CPB1  = 4;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [1:0][7:0] din;
  logic [1:0]      dv;
  logic [1:0]      hold_s;
  wire  [1:0]      acc;
  wire  [1:0]      ser;
  wire  [1:0]      bsy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [7:0] exp0[$];
  logic [7:0] exp1[$];
  int         st0[$];

  logic [1:0] act;
  logic [1:0] stab;
  int         n_s [2];
  logic [9:0] fb  [2];
  int         sent[2];
  logic [1:0] pend;
  logic [7:0] burst[5] = '{8'h00, 8'hFF, 8'h3C, 8'h81, 8'h7E};

  serial_frame_tx #(.CLKS_PER_BIT(CPB0), .FIFO_DEPTH(DEPTH)) dut1 (
    .clk(clk), .reset_n(reset_n), .data_in(din[0]), .data_valid(dv[0]),
    .data_accept(acc[0]), .hold(hold_s[0]), .ser_out(ser[0]), .busy(bsy[0]));

  serial_frame_tx #(.CLKS_PER_BIT(CPB1), .FIFO_DEPTH(DEPTH)) dut4 (
    .clk(clk), .reset_n(reset_n), .data_in(din[1]), .data_valid(dv[1]),
    .data_accept(acc[1]), .hold(hold_s[1]), .ser_out(ser[1]), .busy(bsy[1]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Line decoder: a falling line starts a frame; every bit must stay constant
  // for its whole period, stop must be 1, payload goes to the scoreboard.
  always @(negedge clk) begin
    int cpb;
    int b;
    for (int k = 0; k < 2; k++) begin
      cpb = (k == 0) ? CPB0 : CPB1;
      if (!reset_n) begin
        act[k] = 1'b0;
      end else if (!act[k]) begin
        if (ser[k] == 1'b0) begin
          act[k]  = 1'b1;
          n_s[k]  = 1;
          fb[k]   = '0;
          stab[k] = 1'b1;
          if (k == 0) st0.push_back(cyc);
        end
      end else begin
        b = n_s[k] / cpb;
        if (n_s[k] % cpb == 0) fb[k][b] = ser[k];
        else if (ser[k] != fb[k][b]) stab[k] = 1'b0;
        n_s[k]++;
        if (n_s[k] == 10 * cpb) begin
          act[k] = 1'b0;
          check("bit_stable", stab[k], 1'b1);
          check("stop_bit", fb[k][9], 1'b1);
          if (k == 0) begin
            if (exp0.size() == 0) check("unexpected_frame0", 1, 0);
            else check("frame_data0", fb[k][8:1], exp0.pop_front());
          end else begin
            if (exp1.size() == 0) check("unexpected_frame1", 1, 0);
            else check("frame_data1", fb[k][8:1], exp1.pop_front());
          end
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge right after the transfer edge.
  task automatic write_byte(input int k, input logic [7:0] b);
    int g = 0;
    din[k] = b;
    dv[k]  = 1'b1;
    while (!acc[k] && g < 1000) begin
      @(negedge clk);
      g++;
    end
    check("accept_wait", g < 1000, 1);
    if (k == 0) exp0.push_back(b);
    else exp1.push_back(b);
    @(negedge clk);
    dv[k] = 1'b0;
  endtask

  task automatic drain(input string tag);
    int g = 0;
    while ((exp0.size() != 0 || exp1.size() != 0 || bsy != 2'b00 || act != 2'b00) && g < 3000) begin
      @(negedge clk);
      #1;
      g++;
    end
    check(tag, g < 3000, 1);
  endtask

  initial begin
    logic [9:0] fr;
    logic       idle_ok;
    int         c_rel;

    reset_n = 1'b0;
    din     = '0;
    dv      = '0;
    hold_s  = '0;
    act     = '0;
    pend    = '0;
    repeat (2) @(negedge clk);
    check("rst_ser", ser, 2'b11);
    check("rst_busy", bsy, 2'b00);
    check("rst_accept", acc, 2'b11);
    reset_n = 1'b1;
    @(negedge clk);

    // single byte, one clock per bit
    write_byte(0, 8'hA5);
    check("a5_pre_pop_ser", ser[0], 1'b1);
    check("a5_pre_pop_busy", bsy[0], 1'b1);
    fr = {1'b1, 8'hA5, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("a5_wave", ser[0], fr[i]);
    end
    @(negedge clk);
    check("a5_idle_ser", ser[0], 1'b1);
    check("a5_busy_drop", bsy[0], 1'b0);
    drain("a5_drain");

    // four clocks per bit
    write_byte(1, 8'h5A);
    check("5a_pre_pop_ser", ser[1], 1'b1);
    fr = {1'b1, 8'h5A, 1'b0};
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check("5a_wave", ser[1], fr[i/4]);
    end
    @(negedge clk);
    check("5a_idle_ser", ser[1], 1'b1);
    check("5a_busy_drop", bsy[1], 1'b0);
    drain("5a_drain");

    // burst: fill to full under hold, then a continuous 5-frame stream
    hold_s[0] = 1'b1;
    dv[0]     = 1'b1;
    for (int i = 0; i < 4; i++) begin
      din[0] = burst[i];
      check("burst_accept", acc[0], 1'b1);
      exp0.push_back(burst[i]);
      @(negedge clk);
    end
    din[0] = burst[4];
    for (int i = 0; i < 3; i++) begin
      check("burst_full", acc[0], 1'b0);
      @(negedge clk);
    end
    check("burst_hold_ser", ser[0], 1'b1);
    check("burst_hold_busy", bsy[0], 1'b1);
    st0.delete();
    hold_s[0] = 1'b0;
    c_rel     = cyc;
    @(negedge clk);
    check("accept_after_pop", acc[0], 1'b1);
    exp0.push_back(burst[4]);
    @(negedge clk);
    dv[0] = 1'b0;
    drain("burst_drain");
    check("burst_frames", st0.size(), 5);
    if (st0.size() > 0) check("burst_first_start", st0[0], c_rel + 1);
    for (int i = 1; i < st0.size(); i++) check("burst_gap", st0[i] - st0[0], 10 * i);

    // hold at the start decision and mid-frame
    hold_s[0] = 1'b1;
    write_byte(0, 8'h12);
    write_byte(0, 8'h34);
    for (int i = 0; i < 5; i++) begin
      check("hold_ser", ser[0], 1'b1);
      check("hold_busy", bsy[0], 1'b1);
      @(negedge clk);
    end
    hold_s[0] = 1'b0;
    @(negedge clk);
    check("hold_release_start", ser[0], 1'b0);
    repeat (3) @(negedge clk);
    hold_s[0] = 1'b1;
    repeat (10) @(negedge clk);
    idle_ok = 1'b1;
    repeat (15) begin
      @(negedge clk);
      idle_ok &= ser[0];
    end
    #1;
    check("hold_line_idle", idle_ok, 1'b1);
    check("hold_one_left", exp0.size(), 1);
    check("hold_busy_wait", bsy[0], 1'b1);
    hold_s[0] = 1'b0;
    drain("hold_drain");

    // reset during data bit 3 with two bytes still buffered
    write_byte(0, 8'h00);
    write_byte(0, 8'hAA);
    write_byte(0, 8'h55);
    repeat (3) @(negedge clk);
    check("pre_reset_bit3", ser[0], 1'b0);
    check("pre_reset_busy", bsy[0], 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_ser", ser[0], 1'b1);
    check("async_rst_busy", bsy[0], 1'b0);
    check("async_rst_accept", acc[0], 1'b1);
    exp0.delete();
    exp1.delete();
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    idle_ok = 1'b1;
    repeat (40) begin
      @(negedge clk);
      idle_ok &= ser[0] & ~bsy[0];
    end
    check("post_rst_quiet", idle_ok, 1'b1);
    write_byte(0, 8'hC3);
    drain("post_rst_drain");

    // random stream with gaps and hold toggles on both instances
    sent[0] = 0;
    sent[1] = 0;
    pend    = '0;
    for (int c = 0; c < 4000 && !(sent[0] == 10 && sent[1] == 10 && pend == 2'b00); c++) begin
      for (int k = 0; k < 2; k++) begin
        if (pend[k]) begin
          pend[k] = 1'b0;
          dv[k]   = 1'b0;
        end
        if ($urandom_range(0, 7) == 0) hold_s[k] = ~hold_s[k];
        if (!dv[k] && sent[k] < 10 && $urandom_range(0, 2) == 0) begin
          din[k] = 8'($urandom);
          dv[k]  = 1'b1;
        end
        if (dv[k] && acc[k]) begin
          if (k == 0) exp0.push_back(din[k]);
          else exp1.push_back(din[k]);
          sent[k]++;
          pend[k] = 1'b1;
        end
      end
      @(negedge clk);
    end
    dv     = '0;
    hold_s = '0;
    check("rand_sent0", sent[0], 10);
    check("rand_sent1", sent[1], 10);
    drain("rand_drain");
    check("sb_empty0", exp0.size(), 0);
    check("sb_empty1", exp1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_frame_tx.md
# serial_frame_tx

Transmit end of the chip's serial byte link. Accepts bytes over a valid/accept handshake, buffers them in a small FIFO, and shifts each one out on a single wire as a framed bit stream: start bit, 8 data bits LSB-first, stop bit. The stream is what the chip-side deserializer consumes. The block is used in the bench/host harness that loads weights and input images into the ANN, and it is reusable on-chip for returning results.

## Interface
Parameters:
- CLKS_PER_BIT, default 1: clock cycles per serial bit. Legal range is ≥1.
- FIFO_DEPTH, default 4: byte buffer entries. Must be a power of 2, ≥2.

Ports:
- clk  in  1  single system clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- data_in  in  8  byte to transmit.
- data_valid  in  1  data_in is valid this cycle.
- data_accept  out  1  FIFO can take a byte. A byte is transferred on an edge where data_valid && data_accept.
- hold  in  1  flow control. While high, no new frame starts; a frame already in flight completes.
- ser_out  out  1  serial line. Registered. Idle level is 1.
- busy  out  1  high when a frame is in flight or the FIFO is non-empty.

## Operation
- FIFO:
  - Circular buffer with wr/rd pointers and a count of log2(FIFO_DEPTH)+1 bits.
  - data_accept = (count != FIFO_DEPTH), combinational from count.
  - A write while full is impossible by construction. data_accept stays low when full, even if a pop happens in the same cycle.
  - A simultaneous push and pop (not full) leaves count unchanged. Pointers wrap modulo FIFO_DEPTH.
- FSM states are IDLE, START, DATA, STOP.
  - IDLE: ser_out=1. If count≠0 and hold=0, pop the head into an 8-bit shift register and go to START.
  - START: ser_out=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: ser_out=shreg[0] for CLKS_PER_BIT cycles, then shift right and increment the index. After bit 7, go to STOP.
  - STOP: ser_out=1 for CLKS_PER_BIT cycles. At the end of the last stop cycle: if count≠0 and hold=0, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Bit timer: counter runs 0..CLKS_PER_BIT-1 and resets on every state/bit change. With CLKS_PER_BIT=1 the counter is a constant 0 and each bit lasts one cycle.
- hold is sampled only at the frame-start decision points (IDLE, end of STOP). Asserting it mid-frame does not affect the frame in flight.
- busy = (state≠IDLE) || (count≠0).

## Timing
- Reset values: ser_out=1, busy=0, state=IDLE, count=0, pointers=0, shreg=0, timer=0. data_accept=1 (combinational from count).
- Reset is asynchronous. Asserting it mid-frame forces ser_out high immediately, discards the partial frame and all buffered bytes. No resume after release.
- Latency: a byte accepted on edge N, with FIFO empty, IDLE, and hold=0, is popped on edge N+1. ser_out goes 0 (start bit) after edge N+1.
- Frame length is exactly 10×CLKS_PER_BIT cycles.
- Back-to-back bytes give a continuous stream with no idle bits between a stop bit and the next start bit.
- Throughput is one byte per 10×CLKS_PER_BIT cycles. After a fill of FIFO_DEPTH bytes, data_accept reasserts the cycle after a pop.
- data_accept for a write at edge N reflects count before edge N. A pop on edge N frees a slot visible from edge N onward.

## Test plan
- Single byte, CLKS_PER_BIT=1. Stimulus: write 0xA5. Required: ser_out after the pop edge reads 0,1,0,1,0,0,1,0,1,1, then idles at 1. busy drops after the stop bit.
- Burst, CLKS_PER_BIT=1, FIFO_DEPTH=4. Stimulus: write 0x00,0xFF,0x3C,0x81,0x7E with data_valid held high.
  - data_accept drops after 4 accepted bytes, then rises again after the first pop.
  - All 5 frames appear contiguously, 50 cycles with no gap, and decode to the written values.
- CLKS_PER_BIT=4. Stimulus: write 0x5A. Required: each bit is held exactly 4 cycles. Frame is 40 cycles: start 0, data 0,1,0,1,1,0,1,0, stop 1.
- hold. Stimulus: hold=1, write 0x12 and 0x34.
  - ser_out stays 1 and busy=1.
  - Releasing hold starts the 0x12 frame one edge later.
  - Raising hold mid-frame lets that frame finish; 0x34 waits until hold drops.
- Reset mid-frame. Stimulus: reset_n low during DATA bit 3 with 2 bytes buffered. Required:
  - ser_out=1 asynchronously, busy=0, data_accept=1.
  - After release, no frame is emitted until a new write.
- Wrap-around. Stimulus: stream 10 random bytes with random data_valid gaps and hold toggles. Required: a scoreboard of decoded frames matches the write order exactly, with no loss or duplication.
